rs_fxu: RTL and testbench
=========================

# rs_fxu

Reservation-station bank that feeds one FXU in the Tomasulo core. Accepts decoded ADD/JEQ instructions from dispatch, holds them until both operands are available, snoops the common data bus (CDB) for pending operands, and issues ready entries to the FXU over its valid/rs_num/op/val0/val1/busy interface. It drives that interface from the initiator side; the FXU result returns on the CDB tagged with the issuing station's number.

## Interface
- `BASE`, 0: rs_num of entry 0; entry i carries tag BASE+i.
- `N`, 4: number of entries (1..8).
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `d_valid` in 1: dispatch request this cycle.
- `d_op` in 4: opcode (1 = ADD, 6 = JEQ).
- `d_rdy0`, `d_rdy1` in 1: operand already available.
- `d_val0`, `d_val1` in 16: operand value (used when rdy).
- `d_tag0`, `d_tag1` in 6: producing rs_num (used when not rdy).
- `full` out 1: no free entry; dispatch ignored.
- `d_rs_num` out 6: tag to be assigned to this cycle's dispatch (BASE + lowest free index); don't-care when full.
- `cdb_valid` in 1, `cdb_rs_num` in 6, `cdb_data` in 16: CDB broadcast.
- `fxu_valid` out 1, `fxu_rs_num` out 6, `fxu_op` out 4, `fxu_val0` out 16, `fxu_val1` out 16: issue to FXU.
- `fxu_busy` in 1: FXU busy (combinational in FXU, includes its `valid` input).

## Operation
- Per entry: valid, op, rdy0/val0/tag0, rdy1/val1/tag1.
- Dispatch: if `d_valid && !full`, write the lowest free entry (free = !valid at cycle start). A not-ready operand whose tag matches a same-cycle `cdb_valid` broadcast is captured as ready with `cdb_data`.
- Snoop: every cycle with `cdb_valid`, each valid entry with a not-ready operand whose tag equals `cdb_rs_num` sets rdy and latches `cdb_data`. Both operands may match the same broadcast.
- Issue select: lowest-index entry that is valid with rdy0 && rdy1, using registered state only (no CDB bypass into issue).
- Issue: at an edge where `fxu_busy == 0` and a ready entry exists, register `fxu_valid=1` with that entry's rs_num/op/vals and clear the entry's valid bit. Otherwise `fxu_valid <= 0`. `fxu_valid` is never high two consecutive cycles.
- Simultaneous dispatch and issue: dispatch uses free state at cycle start; the entry freed by issue becomes available next cycle.
- Ops other than 1/6 are stored and issued unchanged; the FXU defines their result.
- `full` = all N valid bits set (combinational from registers).

## Timing
- Reset: all entries invalid; `fxu_valid=0`, `full=0`, `d_rs_num=BASE`; other fxu_* outputs 0. Reset mid-operation discards all entries, including one being dispatched that cycle.
- Dispatch with both rdy at edge e → issuable at edge e+1 if FXU idle; `fxu_valid` high during cycle e+1.
- CDB capture at edge e → entry issuable at edge e+1 earliest.
- With the FXU's handshake (busy high during valid cycle and its compute cycle), back-to-back issues are 3 cycles apart; result appears on CDB 2 cycles after `fxu_valid` rises.
- Issue to FXU is fire-and-forget: no retry, no hold.

## Structure
- Shared package: opcode constants (ADD=1, JEQ=6), tag width 6, data width 16.
- Sub-module `rs_entry`: one station's storage, dispatch write, CDB snoop, ready output; instantiated N times. Select/priority encoding and issue register live in `rs_fxu`.

## Test plan
- Reset, then dispatch ADD rdy 3/4 → `d_rs_num=BASE`; next cycle `fxu_valid=1`, rs_num=BASE, op=1, vals 3/4; entry freed.
- Dispatch ADD with tag0=9 pending, val1=5 ready; CDB broadcasts rs 9 data 7 two cycles later → issue next edge with vals 7/5; unrelated CDB tag 10 does not wake it.
- Dispatch with tag0=9 in the same cycle CDB broadcasts rs 9 data 0x1234 → entry captured ready, issues next edge with val0=0x1234.
- Fill all 4 entries ready with FXU model busy → `full=1`, fifth dispatch ignored; issues in index order 0,1,2,3 spaced 3 cycles; `full` drops after first issue.
- JEQ both operands waiting on same tag 12; CDB rs 12 data 0xFFFF → both captured, issues op=6 vals 0xFFFF/0xFFFF.
- Assert `reset` while 3 entries valid and `fxu_valid` high → next cycle `fxu_valid=0`, `full=0`, `d_rs_num=BASE`, no further issues.

Source files
------------

// File: rtl/rs_fxu_pkg.sv
// Shared widths and opcode constants for the FXU reservation-station bank.
package rs_fxu_pkg;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 16;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd1;
    localparam logic [OP_W-1:0] OP_JEQ = 4'd6;
endpackage

// File: rtl/rs_entry.sv
// One reservation station: holds an instruction, captures pending operands off
// the CDB (including a broadcast coincident with dispatch), reports readiness.
module rs_entry
    import rs_fxu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              clr,
    input  logic [OP_W-1:0]   d_op,
    input  logic              d_rdy0,
    input  logic              d_rdy1,
    input  logic [DATA_W-1:0] d_val0,
    input  logic [DATA_W-1:0] d_val1,
    input  logic [TAG_W-1:0]  d_tag0,
    input  logic [TAG_W-1:0]  d_tag1,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_rs_num,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              valid,
    output logic              ready,
    output logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] val0,
    output logic [DATA_W-1:0] val1
);
    logic              valid_r;
    logic              rdy0_r;
    logic              rdy1_r;
    logic [OP_W-1:0]   op_r;
    logic [DATA_W-1:0] val0_r;
    logic [DATA_W-1:0] val1_r;
    logic [TAG_W-1:0]  tag0_r;
    logic [TAG_W-1:0]  tag1_r;

    logic d_hit0_s;
    logic d_hit1_s;
    logic s_hit0_s;
    logic s_hit1_s;

    assign d_hit0_s = cdb_valid && (cdb_rs_num == d_tag0);
    assign d_hit1_s = cdb_valid && (cdb_rs_num == d_tag1);
    assign s_hit0_s = cdb_valid && valid_r && !rdy0_r && (cdb_rs_num == tag0_r);
    assign s_hit1_s = cdb_valid && valid_r && !rdy1_r && (cdb_rs_num == tag1_r);

    // Station storage: dispatch write (only when free), issue clear, CDB snoop.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            rdy0_r  <= 1'b0;
            rdy1_r  <= 1'b0;
            op_r    <= 4'd0;
            val0_r  <= 16'd0;
            val1_r  <= 16'd0;
            tag0_r  <= 6'd0;
            tag1_r  <= 6'd0;
        end else if (wr) begin
            valid_r <= 1'b1;
            op_r    <= d_op;
            rdy0_r  <= d_rdy0 || d_hit0_s;
            rdy1_r  <= d_rdy1 || d_hit1_s;
            val0_r  <= d_rdy0 ? d_val0 : cdb_data;
            val1_r  <= d_rdy1 ? d_val1 : cdb_data;
            tag0_r  <= d_tag0;
            tag1_r  <= d_tag1;
        end else begin
            if (clr) begin
                valid_r <= 1'b0;
            end
            if (s_hit0_s) begin
                rdy0_r <= 1'b1;
                val0_r <= cdb_data;
            end
            if (s_hit1_s) begin
                rdy1_r <= 1'b1;
                val1_r <= cdb_data;
            end
        end
    end

    assign valid = valid_r;
    assign ready = valid_r && rdy0_r && rdy1_r;
    assign op    = op_r;
    assign val0  = val0_r;
    assign val1  = val1_r;
endmodule

// File: rtl/rs_fxu.sv
// FXU reservation-station bank: N stations, lowest-free dispatch, lowest-ready
// issue into a registered valid/rs_num/op/val0/val1 port towards the FXU.
module rs_fxu
    import rs_fxu_pkg::*;
#(
    parameter int BASE = 0,
    parameter int N    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [OP_W-1:0]   d_op,
    input  logic              d_rdy0,
    input  logic              d_rdy1,
    input  logic [DATA_W-1:0] d_val0,
    input  logic [DATA_W-1:0] d_val1,
    input  logic [TAG_W-1:0]  d_tag0,
    input  logic [TAG_W-1:0]  d_tag1,
    output logic              full,
    output logic [TAG_W-1:0]  d_rs_num,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_rs_num,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              fxu_valid,
    output logic [TAG_W-1:0]  fxu_rs_num,
    output logic [OP_W-1:0]   fxu_op,
    output logic [DATA_W-1:0] fxu_val0,
    output logic [DATA_W-1:0] fxu_val1,
    input  logic              fxu_busy
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]      valid_s;
    logic [N-1:0]      ready_s;
    logic [N-1:0]      wr_s;
    logic [N-1:0]      clr_s;
    logic [OP_W-1:0]   op_s   [N];
    logic [DATA_W-1:0] val0_s [N];
    logic [DATA_W-1:0] val1_s [N];

    logic [IDX_W-1:0]  free_idx_s;
    logic [IDX_W-1:0]  iss_idx_s;
    logic              fire_s;
    logic              full_s;

    // Priority encoders: lowest free station and lowest ready station.
    always_comb begin
        free_idx_s = '0;
        iss_idx_s  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            free_idx_s = !valid_s[i] ? IDX_W'(i) : free_idx_s;
            iss_idx_s  = ready_s[i]  ? IDX_W'(i) : iss_idx_s;
        end
    end

    assign full_s   = &valid_s;
    assign full     = full_s;
    assign d_rs_num = TAG_W'(BASE) + TAG_W'(free_idx_s);

    // Guarding on fxu_valid keeps issues non-consecutive even if busy lags.
    assign fire_s = !fxu_busy && !fxu_valid && (|ready_s);

    for (genvar g = 0; g < N; g++) begin : g_ent
        assign wr_s[g]  = d_valid && !full_s && (free_idx_s == IDX_W'(g));
        assign clr_s[g] = fire_s && (iss_idx_s == IDX_W'(g));

        rs_entry u_ent (
            .clk        (clk),
            .reset      (reset),
            .wr         (wr_s[g]),
            .clr        (clr_s[g]),
            .d_op       (d_op),
            .d_rdy0     (d_rdy0),
            .d_rdy1     (d_rdy1),
            .d_val0     (d_val0),
            .d_val1     (d_val1),
            .d_tag0     (d_tag0),
            .d_tag1     (d_tag1),
            .cdb_valid  (cdb_valid),
            .cdb_rs_num (cdb_rs_num),
            .cdb_data   (cdb_data),
            .valid      (valid_s[g]),
            .ready      (ready_s[g]),
            .op         (op_s[g]),
            .val0       (val0_s[g]),
            .val1       (val1_s[g])
        );
    end

    // Issue register towards the FXU; a one-cycle pulse per issued station.
    always_ff @(posedge clk) begin
        if (reset) begin
            fxu_valid  <= 1'b0;
            fxu_rs_num <= 6'd0;
            fxu_op     <= 4'd0;
            fxu_val0   <= 16'd0;
            fxu_val1   <= 16'd0;
        end else if (fire_s) begin
            fxu_valid  <= 1'b1;
            fxu_rs_num <= TAG_W'(BASE) + TAG_W'(iss_idx_s);
            fxu_op     <= op_s[iss_idx_s];
            fxu_val0   <= val0_s[iss_idx_s];
            fxu_val1   <= val1_s[iss_idx_s];
        end else begin
            fxu_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rs_fxu.sv
// Directed self-checking bench for rs_fxu with a two-cycle-busy FXU model.
module tb_rs_fxu;
    localparam int BASE = 16;
    localparam int N    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_valid;
    logic [3:0]  d_op;
    logic        d_rdy0, d_rdy1;
    logic [15:0] d_val0, d_val1;
    logic [5:0]  d_tag0, d_tag1;
    logic        full;
    logic [5:0]  d_rs_num;
    logic        cdb_valid;
    logic [5:0]  cdb_rs_num;
    logic [15:0] cdb_data;
    logic        fxu_valid;
    logic [5:0]  fxu_rs_num;
    logic [3:0]  fxu_op;
    logic [15:0] fxu_val0, fxu_val1;
    logic        fxu_busy;

    logic        busy_r;
    logic        force_busy;
    int          n_chk  = 0;
    int          n_fail = 0;

    rs_fxu #(.BASE(BASE), .N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_op       (d_op),
        .d_rdy0     (d_rdy0),
        .d_rdy1     (d_rdy1),
        .d_val0     (d_val0),
        .d_val1     (d_val1),
        .d_tag0     (d_tag0),
        .d_tag1     (d_tag1),
        .full       (full),
        .d_rs_num   (d_rs_num),
        .cdb_valid  (cdb_valid),
        .cdb_rs_num (cdb_rs_num),
        .cdb_data   (cdb_data),
        .fxu_valid  (fxu_valid),
        .fxu_rs_num (fxu_rs_num),
        .fxu_op     (fxu_op),
        .fxu_val0   (fxu_val0),
        .fxu_val1   (fxu_val1),
        .fxu_busy   (fxu_busy)
    );

    always #5 clk = ~clk;

    // FXU model: busy during the valid cycle and the following compute cycle.
    always_ff @(posedge clk) begin
        if (reset) busy_r <= 1'b0;
        else       busy_r <= fxu_valid;
    end
    assign fxu_busy = fxu_valid | busy_r | force_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [3:0] op, input logic r0, input logic [15:0] v0,
                        input logic [5:0] t0, input logic r1, input logic [15:0] v1,
                        input logic [5:0] t1);
        d_valid = 1'b1;
        d_op = op; d_rdy0 = r0; d_val0 = v0; d_tag0 = t0;
        d_rdy1 = r1; d_val1 = v1; d_tag1 = t1;
    endtask

    task automatic cdb(input logic v, input logic [5:0] t, input logic [15:0] d);
        cdb_valid = v; cdb_rs_num = t; cdb_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; force_busy = 1'b0; d_valid = 1'b0;
        disp(4'd0, 1'b0, 16'd0, 6'd0, 1'b0, 16'd0, 6'd0);
        d_valid = 1'b0;
        cdb(1'b0, 6'd0, 16'd0);
        step(); step();
        reset = 1'b0;
        chk("rst_valid", 32'(fxu_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_tag", 32'(d_rs_num), 32'(BASE));
        chk("rst_rs", 32'(fxu_rs_num), 32'd0);
        chk("rst_vals", {fxu_val0, fxu_val1}, 32'd0);

        // Ready ADD issues the edge after dispatch
        disp(4'd1, 1'b1, 16'd3, 6'd0, 1'b1, 16'd4, 6'd0);
        chk("t1_tag", 32'(d_rs_num), 32'(BASE));
        step(); d_valid = 1'b0;
        chk("t1_noiss", 32'(fxu_valid), 32'd0);
        step();
        chk("t1_valid", 32'(fxu_valid), 32'd1);
        chk("t1_rs", 32'(fxu_rs_num), 32'(BASE));
        chk("t1_op", 32'(fxu_op), 32'd1);
        chk("t1_vals", {fxu_val0, fxu_val1}, {16'd3, 16'd4});
        chk("t1_freed", 32'(d_rs_num), 32'(BASE));
        step();
        chk("t1_pulse", 32'(fxu_valid), 32'd0);
        step(); step();

        // Pending operand woken by CDB tag 9, not by tag 10
        disp(4'd1, 1'b0, 16'd0, 6'd9, 1'b1, 16'd5, 6'd0);
        step(); d_valid = 1'b0;
        cdb(1'b1, 6'd10, 16'd99);
        step();
        chk("t2_wrongtag", 32'(fxu_valid), 32'd0);
        cdb(1'b1, 6'd9, 16'd7);
        step();
        cdb(1'b0, 6'd0, 16'd0);
        chk("t2_wait", 32'(fxu_valid), 32'd0);
        step();
        chk("t2_valid", 32'(fxu_valid), 32'd1);
        chk("t2_vals", {fxu_val0, fxu_val1}, {16'd7, 16'd5});
        step(); step(); step();

        // CDB broadcast coincident with dispatch is captured
        disp(4'd1, 1'b0, 16'd0, 6'd9, 1'b1, 16'd2, 6'd0);
        cdb(1'b1, 6'd9, 16'h1234);
        step(); d_valid = 1'b0;
        cdb(1'b0, 6'd0, 16'd0);
        step();
        chk("t3_valid", 32'(fxu_valid), 32'd1);
        chk("t3_vals", {fxu_val0, fxu_val1}, {16'h1234, 16'd2});
        step(); step(); step();

        // Fill all entries while FXU busy, then drain in index order
        force_busy = 1'b1;
        for (int i = 0; i < N; i++) begin
            disp(4'd1, 1'b1, 16'(i * 10 + 1), 6'd0, 1'b1, 16'(i * 10 + 2), 6'd0);
            chk("t4_tag", 32'(d_rs_num), 32'(BASE + i));
            step();
        end
        chk("t4_full", 32'(full), 32'd1);
        disp(4'd1, 1'b1, 16'd99, 6'd0, 1'b1, 16'd99, 6'd0);
        step();
        chk("t4_stillfull", 32'(full), 32'd1);
        chk("t4_busyhold", 32'(fxu_valid), 32'd0);
        d_valid = 1'b0; force_busy = 1'b0;
        for (int k = 0; k < N; k++) begin
            step();
            chk("t4_valid", 32'(fxu_valid), 32'd1);
            chk("t4_rs", 32'(fxu_rs_num), 32'(BASE + k));
            chk("t4_val0", 32'(fxu_val0), 32'(k * 10 + 1));
            if (k == 0) chk("t4_unfull", 32'(full), 32'd0);
            step();
            chk("t4_gap1", 32'(fxu_valid), 32'd0);
            step();
            chk("t4_gap2", 32'(fxu_valid), 32'd0);
        end
        step();
        chk("t4_noextra", 32'(fxu_valid), 32'd0);
        step(); step();

        // JEQ with both operands waiting on tag 12
        disp(4'd6, 1'b0, 16'd0, 6'd12, 1'b0, 16'd0, 6'd12);
        step(); d_valid = 1'b0;
        cdb(1'b1, 6'd12, 16'hFFFF);
        step();
        cdb(1'b0, 6'd0, 16'd0);
        chk("t5_wait", 32'(fxu_valid), 32'd0);
        step();
        chk("t5_valid", 32'(fxu_valid), 32'd1);
        chk("t5_op", 32'(fxu_op), 32'd6);
        chk("t5_vals", {fxu_val0, fxu_val1}, 32'hFFFF_FFFF);
        step(); step(); step();

        // Reset mid-operation discards entries and the in-flight dispatch
        force_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            disp(4'd1, 1'b1, 16'(i + 1), 6'd0, 1'b1, 16'd0, 6'd0);
            step();
        end
        d_valid = 1'b0; force_busy = 1'b0;
        step();
        chk("t6_valid", 32'(fxu_valid), 32'd1);
        reset = 1'b1;
        disp(4'd1, 1'b1, 16'd77, 6'd0, 1'b1, 16'd77, 6'd0);
        step();
        reset = 1'b0; d_valid = 1'b0;
        chk("t6_valid0", 32'(fxu_valid), 32'd0);
        chk("t6_full", 32'(full), 32'd0);
        chk("t6_tag", 32'(d_rs_num), 32'(BASE));
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t6_quiet", 32'(fxu_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
